scope_trigger_ctrl: RTL and testbench

- Trigger/capture sequencer for one scope channel's sample buffer.
- Watches the ADC sample stream at the buffer's write-strobe rate and fills pre-trigger history.
- Detects a level crossing with hysteresis, then completes post-trigger capture.
- Freezes the buffer (hold) for a display dwell time; drives the Sample block's hold input in place of the raw switch.

---
 rtl/scope_trigger_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_scope_trigger_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scope_trigger_ctrl.sv
// scope_trigger_ctrl: trigger/capture sequencer for one scope channel.
// Fills pre-trigger history, arms a hysteresis-qualified level trigger
// (or an auto-trigger on timeout), completes post-trigger capture, then
// freezes the sample buffer for a display dwell time.
module scope_trigger_ctrl #(
    parameter int DATA_W       = 12,
    parameter int DEPTH        = 640,
    parameter int PRE_SAMPLES  = 320,
    parameter int HYST         = 8,
    parameter int AUTO_TIMEOUT = 65535,
    parameter int HOLD_CYCLES  = 2500000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] sample_in,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic [1:0]        mode,
    input  logic              arm,
    output logic              hold,
    output logic              wr_en,
    output logic              triggered,
    output logic              auto_flag,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_AUTO   = 2'b00;
    localparam logic [1:0] MODE_SINGLE = 2'b10;

    // Strobes written after the trigger strobe before the buffer is frozen.
    localparam int POST_N    = DEPTH - PRE_SAMPLES - 1;
    localparam int CNT_MAX_A = (PRE_SAMPLES > POST_N) ? PRE_SAMPLES : POST_N;
    localparam int CNT_MAX   = (CNT_MAX_A > HOLD_CYCLES) ? CNT_MAX_A : HOLD_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int TMO_W     = $clog2(AUTO_TIMEOUT + 1);
    localparam int DW1       = DATA_W + 1;

    localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PRE_SAMPLES - 1);
    localparam logic [CNT_W-1:0]  POST_LAST = CNT_W'(POST_N - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(AUTO_TIMEOUT - 1);
    localparam logic [DW1-1:0]    HYST_X    = DW1'(HYST);
    localparam logic [DW1-1:0]    DATA_MAXX = {1'b0, {DATA_W{1'b1}}};

    // Rising-slope re-arm threshold: level minus hysteresis, floored at 0.
    function automatic logic [DATA_W-1:0] sat_sub_hyst(input logic [DATA_W-1:0] lvl);
        logic [DW1-1:0] ext;
        logic [DW1-1:0] diff;
        ext  = {1'b0, lvl};
        diff = ext - HYST_X;
        if (ext < HYST_X) begin
            return '0;
        end
        return diff[DATA_W-1:0];
    endfunction

    // Falling-slope re-arm threshold: level plus hysteresis, capped at full scale.
    function automatic logic [DATA_W-1:0] sat_add_hyst(input logic [DATA_W-1:0] lvl);
        logic [DW1-1:0] sum;
        sum = {1'b0, lvl} + HYST_X;
        if (sum > DATA_MAXX) begin
            return '1;
        end
        return sum[DATA_W-1:0];
    endfunction

    // States in which the buffer is being written (hold released).
    function automatic logic is_capture(input state_t s);
        return (s == S_PRE) || (s == S_ARMED) || (s == S_POST);
    endfunction

    state_t             state_q, state_d;
    logic               hold_q, hold_d;
    logic               trig_q, trig_d;
    logic               auto_q, auto_d;
    logic               qual_q, qual_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;

    logic [DATA_W-1:0]  lo_thr;
    logic [DATA_W-1:0]  hi_thr;
    logic               qual_set;
    logic               hit;
    logic               tmo_hit;

    // Level-crossing detector: qualifier set condition, real hit, and timeout hit.
    always_comb begin
        lo_thr   = sat_sub_hyst(trig_level);
        hi_thr   = sat_add_hyst(trig_level);
        qual_set = 1'b0;
        hit      = 1'b0;
        if (!trig_slope) begin
            qual_set = (sample_in <= lo_thr);
            hit      = qual_q && (sample_in >= trig_level);
        end else begin
            qual_set = (sample_in >= hi_thr);
            hit      = qual_q && (sample_in <= trig_level);
        end
        tmo_hit = (mode == MODE_AUTO) && (tmo_q == TMO_LAST);
    end

    // Sequencer next-state, counters, trigger pulse and auto flag.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        qual_d  = qual_q;
        trig_d  = 1'b0;
        auto_d  = auto_q;

        case (state_q)
            S_IDLE: begin
                // Free-running modes restart at once; single waits for arm.
                if ((mode != MODE_SINGLE) || arm) begin
                    state_d = S_PRE;
                    cnt_d   = '0;
                end
            end
            S_PRE: begin
                if (sample_en) begin
                    if (cnt_q == PRE_LAST) begin
                        state_d = S_ARMED;
                        cnt_d   = '0;
                        qual_d  = 1'b0;
                        tmo_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_ARMED: begin
                if (sample_en) begin
                    if (hit || tmo_hit) begin
                        // A real crossing on the timeout strobe is reported as real.
                        trig_d = 1'b1;
                        auto_d = !hit;
                        cnt_d  = '0;
                        if (POST_N == 0) begin
                            state_d = S_HOLD;
                        end else begin
                            state_d = S_POST;
                        end
                    end else begin
                        qual_d = qual_q | qual_set;
                        if (mode == MODE_AUTO) begin
                            tmo_d = tmo_q + 1'b1;
                        end
                    end
                end
            end
            S_POST: begin
                if (sample_en) begin
                    if (cnt_q == POST_LAST) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    if (mode == MODE_SINGLE) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_PRE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        hold_d = !is_capture(state_d);
    end

    // State, counters and registered outputs; reset freezes the buffer immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            hold_q  <= 1'b1;
            trig_q  <= 1'b0;
            auto_q  <= 1'b0;
            qual_q  <= 1'b0;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            trig_q  <= trig_d;
            auto_q  <= auto_d;
            qual_q  <= qual_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign wr_en     = sample_en && is_capture(state_q);
    assign hold      = hold_q;
    assign triggered = trig_q;
    assign auto_flag = auto_q;
    assign state     = state_q;

endmodule

// File: tb/tb_scope_trigger_ctrl.sv
// Bench for scope_trigger_ctrl: directed captures with a trigger scoreboard.
module tb_scope_trigger_ctrl;

    localparam int DATA_W       = 12;
    localparam int DEPTH        = 10;
    localparam int PRE_SAMPLES  = 4;
    localparam int HYST         = 8;
    localparam int AUTO_TIMEOUT = 20;
    localparam int HOLD_CYCLES  = 5;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PRE   = 3'd1;
    localparam logic [2:0] ST_ARMED = 3'd2;
    localparam logic [2:0] ST_POST  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;

    logic              clock = 1'b0;
    logic              reset;
    logic              sample_en;
    logic [DATA_W-1:0] sample_in;
    logic [DATA_W-1:0] trig_level;
    logic              trig_slope;
    logic [1:0]        mode;
    logic              arm;
    logic              hold;
    logic              wr_en;
    logic              triggered;
    logic              auto_flag;
    logic [2:0]        state;

    scope_trigger_ctrl #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .PRE_SAMPLES (PRE_SAMPLES),
        .HYST        (HYST),
        .AUTO_TIMEOUT(AUTO_TIMEOUT),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .sample_en (sample_en),
        .sample_in (sample_in),
        .trig_level(trig_level),
        .trig_slope(trig_slope),
        .mode      (mode),
        .arm       (arm),
        .hold      (hold),
        .wr_en     (wr_en),
        .triggered (triggered),
        .auto_flag (auto_flag),
        .state     (state)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [DATA_W-1:0] smp;
        logic              af;
    } exp_t;

    exp_t              sbq[$];
    int                n_tests = 0;
    int                n_fail  = 0;
    int                writes = 0;
    int                hold_run = 0;
    int                last_hold_len = 0;
    int                hold_hi_cnt = 0;
    logic [DATA_W-1:0] last_sample = '0;
    bit                stim_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One strobe, then two idle clocks (strobe period of three clocks).
    task automatic strobe(input logic [DATA_W-1:0] v);
        tick();
        sample_en   = 1'b1;
        sample_in   = v;
        last_sample = v;
        tick();
        sample_en = 1'b0;
        tick();
    endtask

    task automatic strobes(input logic [DATA_W-1:0] v, input int n);
        for (int i = 0; i < n; i++) strobe(v);
    endtask

    task automatic push_exp(input logic [DATA_W-1:0] v, input logic af);
        exp_t e;
        e.smp = v;
        e.af  = af;
        sbq.push_back(e);
    endtask

    task automatic arm_pulse();
        tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int maxc, input string name);
        int n;
        n = 0;
        while (state !== s && n < maxc) begin
            tick();
            n++;
        end
        chk(name, state, s);
    endtask

    // Scoreboard monitor: pops an expectation on every trigger pulse.
    task automatic monitor();
        exp_t e;
        while (!stim_done) begin
            @(negedge clock);
            if (wr_en === 1'b1) writes++;
            if (hold === 1'b1) hold_hi_cnt++;
            if (state === ST_HOLD) begin
                hold_run++;
            end else if (hold_run != 0) begin
                last_hold_len = hold_run;
                hold_run      = 0;
            end
            if (triggered === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected_trigger: got trigger at sample %0d, expected none", last_sample);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_trig_sample", 32'(last_sample), 32'(e.smp));
                    chk("sb_auto_flag", 32'(auto_flag), 32'(e.af));
                end
            end
        end
    endtask

    task automatic watchdog();
        for (int i = 0; i < 20000 && !stim_done; i++) @(posedge clock);
        if (!stim_done) begin
            n_tests++;
            n_fail++;
            $display("FAIL watchdog: stimulus still running after 20000 cycles, expected completion");
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $fatal(1, "watchdog expired");
        end
    endtask

    task automatic stimulus();
        // Reset state
        @(posedge clock);
        #1;
        chk("rst_state", state, ST_IDLE);
        chk("rst_hold", hold, 1);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_triggered", triggered, 0);
        chk("rst_auto_flag", auto_flag, 0);
        reset = 1'b0;
        wait_state(ST_PRE, 4, "pre_after_reset");

        // Normal rising ramp, level 100
        writes = 0;
        for (int v = 0; v <= 150; v += 10) begin
            if (v == 100) push_exp(12'd100, 1'b0);
            strobe(DATA_W'(v));
        end
        wait_state(ST_PRE, 20, "t1_back_to_pre");
        tick();
        chk("t1_writes", writes, 16);
        chk("t1_hold_len", last_hold_len, HOLD_CYCLES);
        chk("t1_hold_low", hold, 0);

        // Hysteresis: 95 never qualifies, 90 does
        strobes(12'd95, PRE_SAMPLES);
        strobe(12'd95); strobe(12'd101); strobe(12'd95); strobe(12'd101);
        chk("t2_still_armed", state, ST_ARMED);
        push_exp(12'd101, 1'b0);
        strobe(12'd90); strobe(12'd101);
        strobes(12'd0, 5);
        wait_state(ST_PRE, 20, "t2_back_to_pre");

        // Falling, level 2000 (re-arm at 2008)
        trig_level = 12'd2000;
        trig_slope = 1'b1;
        strobes(12'd2000, PRE_SAMPLES);
        strobe(12'd2005); strobe(12'd1999);
        chk("t3_still_armed", state, ST_ARMED);
        push_exp(12'd1998, 1'b0);
        strobe(12'd2010); strobe(12'd1998);
        strobes(12'd0, 5);
        wait_state(ST_PRE, 20, "t3_back_to_pre");

        // Rising near full scale, level 4090 (re-arm at 4082)
        trig_level = 12'd4090;
        trig_slope = 1'b0;
        strobes(12'd0, PRE_SAMPLES);
        strobe(12'd4083); strobe(12'd4094);
        chk("t4_still_armed", state, ST_ARMED);
        push_exp(12'd4095, 1'b0);
        strobe(12'd4082); strobe(12'd4095);
        strobes(12'd0, 5);
        wait_state(ST_PRE, 20, "t4_back_to_pre");

        // Falling, level 4090: re-arm threshold caps at 4095
        trig_slope = 1'b1;
        strobes(12'd0, PRE_SAMPLES);
        strobe(12'd4094); strobe(12'd4089);
        chk("t5_still_armed", state, ST_ARMED);
        push_exp(12'd4088, 1'b0);
        strobe(12'd4095); strobe(12'd4088);
        strobes(12'd0, 5);
        wait_state(ST_PRE, 20, "t5_back_to_pre");

        // Auto timeout on the 20th ARMED strobe
        mode       = 2'b00;
        trig_level = 12'd100;
        trig_slope = 1'b0;
        strobes(12'd50, PRE_SAMPLES);
        strobes(12'd50, AUTO_TIMEOUT - 1);
        chk("t6_still_armed", state, ST_ARMED);
        push_exp(12'd50, 1'b1);
        strobe(12'd50);
        strobes(12'd0, 5);
        wait_state(ST_PRE, 20, "t6_back_to_pre");

        // Real crossing on the timeout strobe wins
        strobes(12'd50, PRE_SAMPLES);
        strobes(12'd50, AUTO_TIMEOUT - 1);
        push_exp(12'd100, 1'b0);
        strobe(12'd100);
        strobes(12'd0, 5);
        wait_state(ST_PRE, 20, "t7_back_to_pre");

        // Normal mode never times out
        mode = 2'b01;
        hold_hi_cnt = 0;
        strobes(12'd50, PRE_SAMPLES + 100);
        chk("t8_still_armed", state, ST_ARMED);
        chk("t8_hold_never_high", hold_hi_cnt, 0);
        push_exp(12'd100, 1'b0);
        strobe(12'd100);
        strobes(12'd0, 5);

        // Single shot: IDLE after HOLD, waits for arm
        mode = 2'b10;
        wait_state(ST_IDLE, 20, "t9_idle_after_hold");
        repeat (20) tick();
        chk("t9_idle_stays", state, ST_IDLE);
        chk("t9_idle_hold", hold, 1);
        arm_pulse();
        chk("t9_pre_after_arm", state, ST_PRE);
        strobes(12'd0, PRE_SAMPLES);
        push_exp(12'd100, 1'b0);
        strobe(12'd90); strobe(12'd100);
        strobe(12'd0);
        arm_pulse();
        strobes(12'd0, 4);
        wait_state(ST_IDLE, 20, "t9_idle_after_capture");
        repeat (15) tick();
        chk("t9_idle_after_late_arm", state, ST_IDLE);
        chk("t9_hold_after_capture", hold, 1);

        // Async reset in the middle of POST
        arm_pulse();
        strobes(12'd0, PRE_SAMPLES);
        push_exp(12'd100, 1'b0);
        strobe(12'd90); strobe(12'd100);
        strobes(12'd0, 2);
        chk("t10_in_post", state, ST_POST);
        tick();
        sample_en = 1'b1;
        #1;
        chk("t10_wr_before_reset", wr_en, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("t10_rst_state", state, ST_IDLE);
        chk("t10_rst_hold", hold, 1);
        chk("t10_rst_wr_en", wr_en, 0);
        sample_en = 1'b0;
        mode      = 2'b00;
        tick();
        reset = 1'b0;
        chk("t10_rst_triggered", triggered, 0);
        chk("t10_rst_auto_flag", auto_flag, 0);
        tick();
        chk("t10_pre_after_release", state, ST_PRE);
        chk("t10_hold_released", hold, 0);

        repeat (3) tick();
        stim_done = 1'b1;
    endtask

    initial begin
        reset      = 1'b1;
        sample_en  = 1'b0;
        sample_in  = '0;
        trig_level = 12'd100;
        trig_slope = 1'b0;
        mode       = 2'b01;
        arm        = 1'b0;
        fork
            stimulus();
            monitor();
            watchdog();
        join
        chk("sb_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
